// File: rtl/dmem_arbiter_pkg.sv
// Shared types and encodings for the data-memory arbiter and its winner-select helper.
// Optional feature macro DMEM_ARB_PERF_EN is consumed by dmem_arbiter, not here.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef logic owner_t;

  localparam owner_t OWN_CPU = 1'b0;
  localparam owner_t OWN_DBG = 1'b1;

  localparam int STARVE_W = 4;

  function automatic logic is_arb_state(input state_e s);
    return (s == ST_IDLE) || (s == ST_RESP);
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select: CPU has priority unless debug has starved for STARVE_LIMIT
// arbitrations. A winner always exists whenever at least one request is present.
module dmem_arb_pick
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                cpu_req,
  input  logic                dbg_req,
  input  logic [STARVE_W-1:0] starve_cnt,
  output logic                win_valid,
  output owner_t              win_owner
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic starved;

  assign starved = (starve_cnt == LIMIT);

  always_comb begin
    win_valid = cpu_req | dbg_req;
    win_owner = OWN_CPU;
    // A forced debug win only makes sense while debug is still asking.
    if (dbg_req && (starved || !cpu_req)) begin
      win_owner = OWN_DBG;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter (CPU, debug/loader) in front of a 1-cycle synchronous data RAM.
// Define DMEM_ARB_PERF_EN to add the conflict_cnt / dbg_wait_cnt performance counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no access in flight; arbitrate, grant winner
// ST_ISSUE | memory cycle for the registered request (mem_en high)
// ST_RESP  | owner's rvalid; arbitrate again for back-to-back access
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW           = 10,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,

  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,

`ifdef DMEM_ARB_PERF_EN
  output logic [31:0]   conflict_cnt,
  output logic [31:0]   dbg_wait_cnt,
`endif

  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  state_e              state_q,      state_d;
  owner_t              owner_q,      owner_d;
  logic                req_we_q,     req_we_d;
  logic [AW-1:0]       req_addr_q,   req_addr_d;
  logic [DW-1:0]       req_wdata_q,  req_wdata_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

  logic   arb_cycle;
  logic   win_valid;
  owner_t win_owner;

  // Grants are combinational from the request inputs, so hold them off while reset is asserted.
  assign arb_cycle = rst && is_arb_state(state_q);

  dmem_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_pick (
    .cpu_req    (cpu_req),
    .dbg_req    (dbg_req),
    .starve_cnt (starve_cnt_q),
    .win_valid  (win_valid),
    .win_owner  (win_owner)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    req_we_d     = req_we_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    starve_cnt_d = starve_cnt_q;
    cpu_gnt      = 1'b0;
    dbg_gnt      = 1'b0;

    case (state_q)
      ST_IDLE, ST_RESP: begin
        state_d = ST_IDLE;
        if (arb_cycle && win_valid) begin
          state_d = ST_ISSUE;
          owner_d = win_owner;
          if (win_owner == OWN_DBG) begin
            dbg_gnt     = 1'b1;
            req_we_d    = dbg_we;
            req_addr_d  = dbg_addr;
            req_wdata_d = dbg_wdata;
          end else begin
            cpu_gnt     = 1'b1;
            req_we_d    = cpu_we;
            req_addr_d  = cpu_addr;
            req_wdata_d = cpu_wdata;
          end
        end
      end
      ST_ISSUE: state_d = ST_RESP;
      default:  state_d = ST_IDLE;
    endcase

    // A pending debug request that lost this arbitration moves one step closer to a forced win.
    if (!dbg_req || dbg_gnt) begin
      starve_cnt_d = '0;
    end else if (arb_cycle && (starve_cnt_q != LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_CPU;
      req_we_q     <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      req_we_q     <= req_we_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    cpu_rvalid = 1'b0;
    dbg_rvalid = 1'b0;
    cpu_rdata  = '0;
    dbg_rdata  = '0;

    if (state_q == ST_ISSUE) begin
      mem_en    = 1'b1;
      mem_we    = req_we_q;
      mem_addr  = req_addr_q;
      mem_wdata = req_wdata_q;
    end

    // Writes complete with zero data so a stale RAM output never leaks to the requester.
    if (state_q == ST_RESP) begin
      if (owner_q == OWN_DBG) begin
        dbg_rvalid = 1'b1;
        dbg_rdata  = req_we_q ? '0 : mem_rdata;
      end else begin
        cpu_rvalid = 1'b1;
        cpu_rdata  = req_we_q ? '0 : mem_rdata;
      end
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] conflict_cnt_q, conflict_cnt_d;
  logic [31:0] dbg_wait_cnt_q, dbg_wait_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q + 32'(arb_cycle && cpu_req && dbg_req);
    dbg_wait_cnt_d = dbg_wait_cnt_q + 32'(dbg_req && !dbg_gnt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_cnt_q <= '0;
      dbg_wait_cnt_q <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
      dbg_wait_cnt_q <= dbg_wait_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
  assign dbg_wait_cnt = dbg_wait_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table, hand sequences for arbitration corners,
// and a grant-driven scoreboard checking every memory cycle and response.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_gnt, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          dbg_req = 1'b0, dbg_we = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic          dbg_gnt, dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0]   conflict_cnt, dbg_wait_cnt;
`endif

  dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
`ifdef DMEM_ARB_PERF_EN
    .conflict_cnt(conflict_cnt), .dbg_wait_cnt(dbg_wait_cnt),
`endif
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wait_model = 0;
  int dbg_rv_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM outputs the old word on writes too, so a write response that leaks mem_rdata is visible.
  logic [DW-1:0] ram    [0:(1<<AW)-1];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= ram[mem_addr];
      if (mem_we) ram[mem_addr] <= mem_wdata;
    end
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string msg);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, msg);
  endtask

  typedef struct {
    logic          own;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            cyc;
  } sb_t;
  sb_t sbq[$];

  always @(negedge clk) begin
    sb_t e;
    if (!rst) begin
      sbq.delete();
      wait_model = 0;
    end else begin
      if (dbg_req && !dbg_gnt) wait_model++;
      if (dbg_rvalid) dbg_rv_cnt++;
      if (cpu_rvalid || dbg_rvalid) begin
        if (sbq.size() == 0) fail("sb_rvalid", "rvalid with no access outstanding");
        else begin
          e = sbq.pop_front();
          check("sb_rvalid_owner", {30'd0, cpu_rvalid, dbg_rvalid}, e.own ? 32'd1 : 32'd2);
          check("sb_rdata", e.own ? dbg_rdata : cpu_rdata, e.rdata);
          check("sb_resp_latency", cyc - e.cyc, 2);
        end
      end
      if (mem_en) begin
        if (sbq.size() == 0) fail("sb_mem_en", "mem_en with no granted access");
        else begin
          e = sbq[$];
          check("sb_issue_latency", cyc - e.cyc, 1);
          check("sb_mem_we", mem_we, e.we);
          check("sb_mem_addr", mem_addr, e.addr);
          if (e.we) check("sb_mem_wdata", mem_wdata, e.wdata);
        end
      end
      if (cpu_gnt || dbg_gnt) begin
        check("single_gnt", cpu_gnt && dbg_gnt, 1'b0);
        e.own   = dbg_gnt;
        e.we    = dbg_gnt ? dbg_we : cpu_we;
        e.addr  = dbg_gnt ? dbg_addr : cpu_addr;
        e.wdata = dbg_gnt ? dbg_wdata : cpu_wdata;
        e.cyc   = cyc;
        if (e.we) begin
          shadow[e.addr] = e.wdata;
          e.rdata = '0;
        end else begin
          e.rdata = shadow[e.addr];
        end
        sbq.push_back(e);
      end
    end
  end

  // One complete access on one port; entered just after a rising edge.
  task automatic run_txn(input string name, input logic is_dbg, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [DW-1:0] exp);
    int n = 0;
    if (is_dbg) begin dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; end
    else        begin cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; end
    @(negedge clk);
    while (!(is_dbg ? dbg_gnt : cpu_gnt) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      fail({name, "_gnt"}, "no grant within 20 cycles");
      cpu_req = 1'b0; dbg_req = 1'b0;
      @(posedge clk); #1;
      return;
    end
    @(posedge clk); #1;
    if (is_dbg) dbg_req = 1'b0; else cpu_req = 1'b0;
    @(negedge clk);
    check({name, "_mem_en"}, mem_en, 1'b1);
    check({name, "_mem_we"}, mem_we, we);
    @(negedge clk);
    check({name, "_rvalid"}, is_dbg ? dbg_rvalid : cpu_rvalid, 1'b1);
    check({name, "_rdata"}, is_dbg ? dbg_rdata : cpu_rdata, exp);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic          dbg;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t vt[8];

  initial begin
    int g, n, cpu_wins, arbs, dbg_at, prev, rv_before;

    vt[0] = '{1'b0, 1'b1, 10'd5,    32'hDEAD_BEEF, 32'h0};
    vt[1] = '{1'b0, 1'b0, 10'd5,    32'h0,         32'hDEAD_BEEF};
    vt[2] = '{1'b1, 1'b1, 10'd7,    32'h1234_5678, 32'h0};
    vt[3] = '{1'b1, 1'b0, 10'd7,    32'h0,         32'h1234_5678};
    vt[4] = '{1'b0, 1'b0, 10'd7,    32'h0,         32'h1234_5678};
    vt[5] = '{1'b1, 1'b0, 10'd5,    32'h0,         32'hDEAD_BEEF};
    vt[6] = '{1'b0, 1'b1, 10'd1023, 32'hFFFF_FFFF, 32'h0};
    vt[7] = '{1'b1, 1'b0, 10'd1023, 32'h0,         32'hFFFF_FFFF};

    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = '0;
      shadow[i] = '0;
    end

    // Reset with both requests high: grants must stay low.
    cpu_req = 1'b1; dbg_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_gnt", cpu_gnt, 1'b0);
    check("rst_dbg_gnt", dbg_gnt, 1'b0);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_rvalid", {cpu_rvalid, dbg_rvalid}, '0);
    cpu_req = 1'b0; dbg_req = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++)
      run_txn($sformatf("vec%0d", i), vt[i].dbg, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp);

    // Simultaneous requests: CPU first, debug two cycles later.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd5;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 10'd7;
    @(negedge clk);
    check("simul_cpu_gnt", cpu_gnt, 1'b1);
    check("simul_dbg_lose", dbg_gnt, 1'b0);
    g = cyc;
    @(posedge clk); #1 cpu_req = 1'b0;
    @(negedge clk);
    check("simul_issue_no_gnt", {cpu_gnt, dbg_gnt}, '0);
    @(negedge clk);
    check("simul_dbg_gnt", dbg_gnt, 1'b1);
    check("simul_dbg_gnt_cycle", cyc - g, 2);
    @(posedge clk); #1 dbg_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Starvation: both held high from a fresh reset.
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd5;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 10'd100; dbg_wdata = 32'hA5A5_0064;
    cpu_wins = 0; arbs = 0; dbg_at = 0; n = 0;
    while (dbg_at == 0 && n < 40) begin
      @(negedge clk);
      n++;
      if (cpu_gnt) begin arbs++; cpu_wins++; end
      if (dbg_gnt) begin arbs++; dbg_at = arbs; end
    end
    if (dbg_at == 0) fail("starve_dbg_gnt", "debug never granted within 40 cycles");
    check("starve_cpu_wins", cpu_wins, 4);
    check("starve_dbg_arb_index", dbg_at, 5);
    @(posedge clk); #1 dbg_addr = 10'd101;
    @(negedge clk);
`ifdef DMEM_ARB_PERF_EN
    check("perf_conflict_cnt", conflict_cnt, 32'd5);
`endif
    @(negedge clk);
    check("starve_cleared_cpu_wins", {cpu_gnt, dbg_gnt}, 2'b10);
    @(posedge clk); #1;
    cpu_req = 1'b0; dbg_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
`ifdef DMEM_ARB_PERF_EN
    check("perf_dbg_wait_cnt", dbg_wait_cnt, wait_model);
`endif

    // Debug preload, back-to-back.
    rv_before = dbg_rv_cnt;
    prev = 0;
    dbg_req = 1'b1; dbg_we = 1'b1;
    for (int i = 0; i < 20; i++) begin
      dbg_addr = AW'(i);
      dbg_wdata = DW'(i * 3);
      n = 0;
      do begin @(negedge clk); n++; end while (!dbg_gnt && n < 10);
      if (!dbg_gnt) begin
        fail("preload_gnt", $sformatf("no grant for word %0d", i));
        break;
      end
      if (i > 0) check($sformatf("preload_gap%0d", i), cyc - prev, 2);
      prev = cyc;
      @(posedge clk); #1;
    end
    dbg_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("preload_rvalid_pulses", dbg_rv_cnt - rv_before, 20);
    for (int i = 0; i < 20; i++)
      run_txn($sformatf("readback%0d", i), 1'b0, 1'b0, AW'(i), '0, DW'(i * 3));

    // Reset asserted while an access is in ISSUE.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd7;
    @(negedge clk);
    check("rstmid_gnt", cpu_gnt, 1'b1);
    @(posedge clk); #1 cpu_req = 1'b0;
    @(negedge clk);
    check("rstmid_in_issue", mem_en, 1'b1);
    #1 rst = 1'b0;
    #1;
    check("rstmid_mem_en", mem_en, 1'b0);
    check("rstmid_mem_addr", mem_addr, '0);
    check("rstmid_outputs", {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_we}, '0);
    check("rstmid_rdata", cpu_rdata | dbg_rdata, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rstmid_idle_after", {mem_en, cpu_rvalid, dbg_rvalid}, '0);
    end

    check("sb_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
